mfp_ahb_lite_simple_master: RTL and testbench
=============================================

# mfp_ahb_lite_simple_master

Single-outstanding AHB-Lite master that turns a valid/ready request interface into one SINGLE AHB-Lite transfer at a time. It performs each transfer in two phases, address then data, honours slave wait states and two-cycle ERROR responses, and returns read data or status on a one-cycle response strobe. It is the initiator side for the AHB-Lite RAM and peripheral slaves. It is used by DMA-style helpers and test harnesses that must drive the bus without the CPU.

## Interface
- HPROT_VALUE, 4'b0011, constant driven on HPROT (non-cacheable, non-bufferable, privileged, data).
- HCLK  in  1  single clock; all logic on posedge.
- HRESET  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready at posedge.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- req_wdata  in  32  write data, right-justified (byte in [7:0], halfword in [15:0]).
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  32  raw HRDATA word for reads; 0 for writes and errors.
- rsp_error  out  1  qualifies rsp_valid: ERROR response or misaligned/illegal request.
- HADDR  out  32; HBURST  out  3 (always 3'b000 SINGLE); HMASTLOCK  out  1 (always 0); HPROT  out  4; HSIZE  out  3; HTRANS  out  2; HWDATA  out  32; HWRITE  out  1.
- HRDATA  in  32; HREADY  in  1 (bus-level ready); HRESP  in  1.

## Operation
- States: IDLE, ADDR, DATA, ERR.
- IDLE:
  - req_ready = 1.
  - On acceptance of a legal request: register HADDR, HWRITE and HSIZE = {1'b0, req_size}; store the replicated write data; go to ADDR.
  - Write data replication: byte → {4{wdata[7:0]}}, halfword → {2{wdata[15:0]}}, word → unchanged.
- Illegal request: req_size = 3, halfword with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - Accepted, but no bus transfer is issued. HTRANS stays IDLE.
  - Go to ERR. ERR lasts one cycle and produces rsp_valid = 1, rsp_error = 1.
- ADDR:
  - HTRANS = NONSEQ (2'b10).
  - Hold all address-phase signals while HREADY = 0.
  - On HREADY = 1 go to DATA.
- DATA:
  - HTRANS = IDLE (2'b00).
  - HWDATA is driven with the stored replicated data and held until the phase completes.
  - HREADY = 0, HRESP = 0: wait (unbounded).
  - HREADY = 0, HRESP = 1: first ERROR cycle. HTRANS is already IDLE, so no action; keep waiting.
  - HREADY = 1: phase complete. Register rsp_valid = 1 and rsp_error = HRESP. Register rsp_rdata = HRDATA when this is a read with HRESP = 0, else 0. Go to IDLE.
- req_ready = 0 in ADDR, DATA and ERR. The earliest next acceptance is the cycle rsp_valid is high.
- Reset:
  - Reset values: state = IDLE, HTRANS = IDLE, HADDR = 0, HWRITE = 0, HSIZE = 0, HWDATA = 0, rsp_valid = 0, rsp_error = 0, rsp_rdata = 0, req_ready = 1 (after reset deasserts).
  - A reset during ADDR or DATA abandons the transfer with no response.

## Timing
- Acceptance at edge 0.
  - Cycle 1 (after edge 0): NONSEQ address phase.
  - Cycle 2 (after edge 1): data phase, with 0 wait states.
  - Edge 2: HREADY sampled.
  - Cycle 3 (after edge 2): rsp_valid = 1.
- Request-to-response latency is 3 cycles plus N slave wait states plus M cycles of HREADY = 0 during the address phase.
- Illegal request: rsp_valid in cycle 2 (1 cycle in ERR).
- HWDATA is valid for the whole data phase. It changes only when leaving DATA.
- rsp_valid is never high for 2 consecutive cycles.

## Test plan
- Word write 0xDEADBEEF to 0x0000_0010, then word read of 0x10 against the RAM slave:
  - Write: HTRANS = 2 for 1 cycle, HSIZE = 2, HWRITE = 1. rsp_valid 3 cycles after acceptance with rsp_error = 0 and rsp_rdata = 0.
  - Read: rsp_rdata = 0xDEADBEEF.
- Byte write 0xA5 to 0x13, then word read of 0x10:
  - HWDATA = 0xA5A5A5A5 and HSIZE = 0 during the write.
  - The read returns 0xA5ADBEEF.
- Slave stalls 3 cycles (HREADY = 0) in the data phase:
  - HADDR and HWDATA stable throughout.
  - rsp_valid at cycle 6 after acceptance.
  - req_ready = 0 until then.
- Two-cycle ERROR (HRESP = 1 with HREADY = 0, then HRESP = 1 with HREADY = 1):
  - HTRANS = IDLE in both cycles.
  - rsp_valid = 1, rsp_error = 1, rsp_rdata = 0.
- Misaligned cases: word at 0x2, halfword at 0x1, and req_size = 3:
  - No NONSEQ on HTRANS.
  - rsp_error = 1 two cycles after acceptance.
- HRESET asserted while in DATA:
  - Next cycle: HTRANS = 0, rsp_valid = 0, req_ready = 1.
  - A new request then completes normally.

Source files
------------

// File: rtl/mfp_ahb_lite_simple_master.sv
// Single-outstanding AHB-Lite master: one SINGLE transfer per valid/ready request,
// address phase then data phase, with a one-cycle response strobe.
module mfp_ahb_lite_simple_master #(
  parameter logic [3:0] HPROT_VALUE = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_t;

  state_t      state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [2:0]  hsize_q, hsize_d;
  logic        hwrite_q, hwrite_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_error_q, rsp_error_d;
  logic        req_illegal;
  logic [31:0] wdata_rep;

  always_comb begin
    req_illegal = 1'b0;
    wdata_rep   = req_wdata;
    unique case (req_size)
      2'd0: wdata_rep = {4{req_wdata[7:0]}};
      2'd1: begin
        wdata_rep   = {2{req_wdata[15:0]}};
        req_illegal = req_addr[0];
      end
      2'd2: req_illegal = (req_addr[1:0] != 2'b00);
      default: req_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = rsp_error_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          // Illegal requests are consumed without touching the bus registers.
          if (req_illegal) begin
            state_d = S_ERR;
          end else begin
            state_d  = S_ADDR;
            haddr_d  = req_addr;
            hwrite_d = req_write;
            hsize_d  = {1'b0, req_size};
            hwdata_d = wdata_rep;
          end
        end
      end
      S_ADDR: if (HREADY) state_d = S_DATA;
      S_DATA: begin
        if (HREADY) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_error_d = HRESP;
          rsp_rdata_d = (!hwrite_q && !HRESP) ? HRDATA : '0;
        end
      end
      S_ERR: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_error_d = 1'b1;
        rsp_rdata_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign HTRANS    = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HWDATA    = hwdata_q;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VALUE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mfp_ahb_lite_simple_master.sv
// Bench for mfp_ahb_lite_simple_master: behavioural RAM slave with wait/error injection,
// response scoreboard, and per-feature timing checks.
module tb_mfp_ahb_lite_simple_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HBURST, HSIZE;
  logic        HMASTLOCK, HWRITE, HREADY, HRESP;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  int errors = 0;
  int checks = 0;

  always #5 HCLK = ~HCLK;

  mfp_ahb_lite_simple_master dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  // RAM slave model
  logic [7:0]  mem [0:255];
  logic        dp_active, dp_write, dp_err, err_phase;
  logic [31:0] dp_addr;
  logic [2:0]  dp_size;
  int          dp_wait;
  int          cfg_waits = 0;
  logic        cfg_err = 1'b0;
  logic [7:0]  ba;
  logic [3:0]  lane_en;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    dp_active = 1'b0; dp_write = 1'b0; dp_err = 1'b0; err_phase = 1'b0;
    dp_addr = '0; dp_size = '0; dp_wait = 0;
  end

  always_comb begin
    ba      = {dp_addr[7:2], 2'b00};
    HREADY  = !dp_active || (dp_wait == 0 && (!dp_err || err_phase));
    HRESP   = dp_active && dp_err && (dp_wait == 0);
    HRDATA  = (dp_active && !dp_write) ?
              {mem[ba + 8'd3], mem[ba + 8'd2], mem[ba + 8'd1], mem[ba]} : 32'h0;
    case (dp_size)
      3'd0:    lane_en = 4'b0001 << dp_addr[1:0];
      3'd1:    lane_en = dp_addr[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  always @(posedge HCLK) begin
    if (HRESET) begin
      dp_active <= 1'b0;
    end else begin
      if (dp_active) begin
        if (HREADY) begin
          dp_active <= 1'b0;
          if (dp_write && !HRESP)
            for (int k = 0; k < 4; k++)
              if (lane_en[k]) mem[ba + 8'(k)] <= HWDATA[8*k +: 8];
        end else if (dp_wait != 0) begin
          dp_wait <= dp_wait - 1;
        end else begin
          err_phase <= 1'b1;
        end
      end
      if (HREADY && HTRANS[1]) begin
        dp_active <= 1'b1;
        dp_addr   <= HADDR;
        dp_write  <= HWRITE;
        dp_size   <= HSIZE;
        dp_wait   <= cfg_waits;
        dp_err    <= cfg_err;
        err_phase <= 1'b0;
      end
    end
  end

  // Response scoreboard: {rsp_error, rsp_rdata}
  logic [32:0] exp_q[$];
  logic        prev_rv = 1'b0;

  always @(negedge HCLK) begin
    logic [32:0] e;
    if (HRESET) begin
      prev_rv = 1'b0;
    end else begin
      if (rsp_valid) begin
        checks++;
        if (prev_rv) begin
          errors++;
          $display("FAIL rsp_consecutive: rsp_valid high two cycles in a row at %0t", $time);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got err=%b rdata=%h, none expected", rsp_error, rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_error, rsp_rdata} !== e) begin
            errors++;
            $display("FAIL rsp_data: got err=%b rdata=%h want err=%b rdata=%h",
                     rsp_error, rsp_rdata, e[32], e[31:0]);
          end
        end
      end
      prev_rv = rsp_valid;
    end
  end

  typedef struct {
    int          lat;
    int          nonseq;
    bit          rdy_low;
    bit          stable;
    bit          dp_idle;
    bit          ready_at_rsp;
    logic [31:0] dp_wdata;
    logic [31:0] ap_addr;
    logic [2:0]  ap_size;
    logic        ap_write;
  } obs_t;

  // Drives one request from a negedge and observes it until the response strobe.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] exp_rdata, output obs_t o);
    bit seen_dp = 0;
    o.lat = -1; o.nonseq = 0; o.rdy_low = 1; o.stable = 1; o.dp_idle = 1;
    o.ready_at_rsp = 0; o.dp_wdata = '0; o.ap_addr = '0; o.ap_size = '0; o.ap_write = 1'b0;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge HCLK);
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_wait: got 0 want 1 within 20 cycles");
      return;
    end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size; req_wdata = wdata;
    exp_q.push_back({exp_err, exp_rdata});
    @(posedge HCLK);
    for (int i = 1; i <= 60; i++) begin
      @(negedge HCLK);
      req_valid = 1'b0;
      if (HTRANS == 2'b10) begin
        o.nonseq++; o.ap_addr = HADDR; o.ap_size = HSIZE; o.ap_write = HWRITE;
      end
      if (dp_active) begin
        if (HTRANS != 2'b00) o.dp_idle = 0;
        if (!seen_dp) o.dp_wdata = HWDATA;
        else if (HWDATA !== o.dp_wdata || HADDR !== o.ap_addr) o.stable = 0;
        seen_dp = 1;
      end
      if (rsp_valid) begin
        o.lat = i;
        o.ready_at_rsp = req_ready;
        break;
      end
      if (req_ready) o.rdy_low = 0;
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK); HRESET = 1'b0;
    @(negedge HCLK);
    checks++;
    if ({HTRANS, HADDR, HWRITE, HSIZE, HWDATA} !== {2'b00, 32'h0, 1'b0, 3'b000, 32'h0}) begin
      errors++;
      $display("FAIL reset_bus: got trans=%b addr=%h wr=%b size=%h wdata=%h want all zero",
               HTRANS, HADDR, HWRITE, HSIZE, HWDATA);
    end
    checks++;
    if ({rsp_valid, rsp_error, rsp_rdata, req_ready} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h ready=%b want 0 0 0 1",
               rsp_valid, rsp_error, rsp_rdata, req_ready);
    end
    checks++;
    if ({HBURST, HMASTLOCK, HPROT} !== {3'b000, 1'b0, 4'b0011}) begin
      errors++;
      $display("FAIL reset_const: got burst=%b lock=%b prot=%b want 000 0 0011", HBURST, HMASTLOCK, HPROT);
    end
  endtask

  task automatic test_word_rw();
    obs_t o;
    do_req(1'b1, 32'h10, 2'd2, 32'hDEADBEEF, 1'b0, 32'h0, o);
    checks++;
    if (o.lat !== 3 || o.nonseq !== 1) begin
      errors++; $display("FAIL wr_timing: got lat=%0d nonseq=%0d want 3 1", o.lat, o.nonseq);
    end
    checks++;
    if ({o.ap_addr, o.ap_size, o.ap_write} !== {32'h10, 3'd2, 1'b1}) begin
      errors++; $display("FAIL wr_addrphase: got addr=%h size=%0d wr=%b want 10 2 1", o.ap_addr, o.ap_size, o.ap_write);
    end
    checks++;
    if (o.dp_wdata !== 32'hDEADBEEF || !o.rdy_low || !o.ready_at_rsp) begin
      errors++; $display("FAIL wr_dataphase: got wdata=%h rdy_low=%b rdy_rsp=%b want deadbeef 1 1",
                         o.dp_wdata, o.rdy_low, o.ready_at_rsp);
    end
    do_req(1'b0, 32'h10, 2'd2, 32'h0, 1'b0, 32'hDEADBEEF, o);
    checks++;
    if (o.lat !== 3 || o.ap_write !== 1'b0) begin
      errors++; $display("FAIL rd_timing: got lat=%0d wr=%b want 3 0", o.lat, o.ap_write);
    end
  endtask

  task automatic test_subword();
    obs_t o;
    do_req(1'b1, 32'h13, 2'd0, 32'h000000A5, 1'b0, 32'h0, o);
    checks++;
    if (o.dp_wdata !== 32'hA5A5A5A5 || o.ap_size !== 3'd0) begin
      errors++; $display("FAIL byte_wr: got wdata=%h size=%0d want a5a5a5a5 0", o.dp_wdata, o.ap_size);
    end
    do_req(1'b0, 32'h10, 2'd2, 32'h0, 1'b0, 32'hA5ADBEEF, o);
    do_req(1'b1, 32'h42, 2'd1, 32'hFFFF1234, 1'b0, 32'h0, o);
    checks++;
    if (o.dp_wdata !== 32'h12341234 || o.ap_size !== 3'd1) begin
      errors++; $display("FAIL half_wr: got wdata=%h size=%0d want 12341234 1", o.dp_wdata, o.ap_size);
    end
    do_req(1'b0, 32'h40, 2'd2, 32'h0, 1'b0, 32'h12340000, o);
  endtask

  task automatic test_stall();
    obs_t o;
    cfg_waits = 3;
    do_req(1'b1, 32'h30, 2'd2, 32'h11223344, 1'b0, 32'h0, o);
    cfg_waits = 0;
    checks++;
    if (o.lat !== 6) begin
      errors++; $display("FAIL stall_lat: got %0d want 6", o.lat);
    end
    checks++;
    if (!o.stable || !o.rdy_low || o.dp_wdata !== 32'h11223344 || o.ap_addr !== 32'h30) begin
      errors++; $display("FAIL stall_hold: got stable=%b rdy_low=%b wdata=%h addr=%h want 1 1 11223344 30",
                         o.stable, o.rdy_low, o.dp_wdata, o.ap_addr);
    end
    do_req(1'b0, 32'h30, 2'd2, 32'h0, 1'b0, 32'h11223344, o);
  endtask

  task automatic test_error();
    obs_t o;
    cfg_err = 1'b1;
    do_req(1'b0, 32'h10, 2'd2, 32'h0, 1'b1, 32'h0, o);
    cfg_err = 1'b0;
    checks++;
    if (o.lat !== 4 || !o.dp_idle || o.nonseq !== 1) begin
      errors++; $display("FAIL err_resp: got lat=%0d dp_idle=%b nonseq=%0d want 4 1 1", o.lat, o.dp_idle, o.nonseq);
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    logic [31:0] addrs [3] = '{32'h2, 32'h1, 32'h0};
    logic [1:0]  sizes [3] = '{2'd2, 2'd1, 2'd3};
    for (int i = 0; i < 3; i++) begin
      do_req(1'b1, addrs[i], sizes[i], 32'hCAFEF00D, 1'b1, 32'h0, o);
      checks++;
      if (o.lat !== 2 || o.nonseq !== 0) begin
        errors++; $display("FAIL illegal_%0d: got lat=%0d nonseq=%0d want 2 0", i, o.lat, o.nonseq);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    do_req(1'b0, 32'h40, 2'd2, 32'h0, 1'b0, 32'h12340000, o);
    do_req(1'b0, 32'h10, 2'd2, 32'h0, 1'b0, 32'hA5ADBEEF, o);
    checks++;
    if (o.lat !== 3 || !o.ready_at_rsp) begin
      errors++; $display("FAIL b2b: got lat=%0d rdy_rsp=%b want 3 1", o.lat, o.ready_at_rsp);
    end
  endtask

  task automatic test_reset_in_data();
    obs_t o;
    cfg_waits = 5;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_size = 2'd2; req_wdata = 32'h12345678;
    @(posedge HCLK);
    @(negedge HCLK); req_valid = 1'b0;
    @(negedge HCLK);
    checks++;
    if (!dp_active || HTRANS !== 2'b00) begin
      errors++; $display("FAIL rst_setup: got dp_active=%b trans=%b want 1 00", dp_active, HTRANS);
    end
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    cfg_waits = 0;
    checks++;
    if ({HTRANS, rsp_valid, req_ready} !== {2'b00, 1'b0, 1'b1}) begin
      errors++; $display("FAIL rst_data: got trans=%b valid=%b ready=%b want 00 0 1", HTRANS, rsp_valid, req_ready);
    end
    do_req(1'b0, 32'h10, 2'd2, 32'h0, 1'b0, 32'hA5ADBEEF, o);
    checks++;
    if (o.lat !== 3) begin
      errors++; $display("FAIL rst_recover: got lat=%0d want 3", o.lat);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_word_rw();
    test_subword();
    test_stall();
    test_error();
    test_illegal();
    test_back_to_back();
    test_reset_in_data();
    repeat (3) @(negedge HCLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
